// File: rtl/ram16x1_pkg.sv
// Shared sizes and load-FSM state encoding for the 16x1 writable LUT RAM.
package ram16x1_pkg;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;
endpackage

// File: rtl/lut16_mem.sv
// 16x1 distributed storage: one synchronous write port, two combinational read ports.
module lut16_mem
    import ram16x1_pkg::*;
#(
    parameter logic [DEPTH-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic              wd,
    input  logic [ADDR_W-1:0] ra,
    output logic              rd,
    input  logic [ADDR_W-1:0] va,
    output logic              vd
);
    logic [DEPTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst)
            mem <= INIT;
        else if (we)
            mem[wa] <= wd;
    end

    assign rd = mem[ra];
    assign vd = mem[va];
endmodule

// File: rtl/ram16x1_loader.sv
// Writable 16x1 LUT RAM with a serial load-and-verify path and a direct bit write.
module ram16x1_loader
    import ram16x1_pkg::*;
#(
    parameter logic [DEPTH-1:0] INIT = 16'h0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              A0,
    input  logic              A1,
    input  logic              A2,
    input  logic              A3,
    output logic              O,
    input  logic              LD_VALID,
    input  logic [DEPTH-1:0]  LD_DATA,
    output logic              LD_READY,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic              D,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);
    state_t             state, state_nx;
    logic [ADDR_W-1:0]  cnt, cnt_nx;
    logic [DEPTH-1:0]   shadow;
    logic               err_q;
    logic               accept;
    logic               mem_we, mem_wd, vd;
    logic [ADDR_W-1:0]  mem_wa;

    assign LD_READY = (state == ram16x1_pkg::IDLE);
    assign BUSY     = !LD_READY;
    assign DONE     = (state == ram16x1_pkg::DONE);
    assign ERR      = err_q;
    assign accept   = LD_VALID && LD_READY;

    // In IDLE an accepted load takes priority over the direct write port.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mem_we   = 1'b0;
        mem_wa   = WA;
        mem_wd   = D;
        case (state)
            ram16x1_pkg::IDLE: begin
                if (accept) begin
                    state_nx = ram16x1_pkg::WRITE;
                    cnt_nx   = '0;
                end else if (WE) begin
                    mem_we = 1'b1;
                end
            end
            ram16x1_pkg::WRITE: begin
                mem_we = 1'b1;
                mem_wa = cnt;
                mem_wd = shadow[cnt];
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd15)
                    state_nx = ram16x1_pkg::VERIFY;
            end
            ram16x1_pkg::VERIFY: begin
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd15)
                    state_nx = ram16x1_pkg::DONE;
            end
            default: state_nx = ram16x1_pkg::IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ram16x1_pkg::IDLE;
            cnt    <= '0;
            shadow <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                shadow <= LD_DATA;
                err_q  <= 1'b0;
            end else if (state == ram16x1_pkg::VERIFY && vd != shadow[cnt]) begin
                err_q <= 1'b1;
            end
        end
    end

    lut16_mem #(.INIT(INIT)) u_mem (
        .clk (CLK),
        .rst (RST),
        .we  (mem_we),
        .wa  (mem_wa),
        .wd  (mem_wd),
        .ra  ({A3, A2, A1, A0}),
        .rd  (O),
        .va  (cnt),
        .vd  (vd)
    );
endmodule
